fft_frame_pingpong_buffer: RTL and testbench

- Collects a serial sample stream into fixed-length frames for the FFT datapath.
- Holds two banks in ping-pong fashion, so input keeps streaming while the FFT core consumes the previous frame.
- Presents a whole frame in parallel on a flattened bus.
- Uses valid/ready handshakes on both sides, with a sticky overrun flag and a synchronous flush.

---
 rtl/fft_frame_pingpong_buffer.sv | 198 +++++++++++++++++++
 tb/tb_fft_frame_pingpong_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// fft_frame_pingpong_buffer
//
// Collects a serial sample stream into FRAME_LEN-sample frames held in two
// ping-pong banks. While the FFT core consumes one complete frame (presented
// in parallel on out_data), the other bank keeps filling from the input.
//
// Optional feature (compile-time macro):
//   FFT_BITREV_WRITE_EN - when defined, each sample is written to the slot
//                         bit_reverse(wr_idx), so out_data carries the frame
//                         in bit-reversed order for a DIT butterfly stage.
//                         Handshake, flags and timing do not change.
//
// Parameters:
//   DATA_WIDTH  width of one sample
//   FRAME_LEN   samples per frame (power of two, >= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   flush      synchronous clear of frame state (bank contents kept)
//   in_valid   in_data holds a sample
//   in_data    input sample
//   in_ready   buffer accepts a sample this cycle
//   out_valid  a complete frame is on out_data
//   out_ready  consumer takes the frame this cycle
//   out_data   frame, sample slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   level      number of full banks (0..2)
//   full       both banks full
//   empty      no full bank and no partial frame
//   overrun    sticky: a sample was offered while in_ready was low
// ---------------------------------------------------------------------------
module fft_frame_pingpong_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [FRAME_LEN*DATA_WIDTH-1:0] out_data,
  output logic [1:0]                      level,
  output logic                            full,
  output logic                            empty,
  output logic                            overrun
);

  localparam int IDX_WIDTH = $clog2(FRAME_LEN);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_LEN - 1);
  localparam logic [IDX_WIDTH-1:0] ZERO_IDX = {IDX_WIDTH{1'b0}};
  localparam logic [IDX_WIDTH-1:0] ONE_IDX  = {{(IDX_WIDTH-1){1'b0}}, 1'b1};

  // Mirror an index across IDX_WIDTH bits (bit b <-> bit IDX_WIDTH-1-b).
  function automatic logic [IDX_WIDTH-1:0] bit_reverse(input logic [IDX_WIDTH-1:0] idx);
    logic [IDX_WIDTH-1:0] rev;
    rev = {IDX_WIDTH{1'b0}};
    for (int b = 0; b < IDX_WIDTH; b++) begin
      rev[b] = idx[IDX_WIDTH-1-b];
    end
    return rev;
  endfunction

  // Storage and frame-state registers
  logic [DATA_WIDTH-1:0] bank_r [2][FRAME_LEN];
  logic                  wr_bank_r;
  logic                  rd_bank_r;
  logic [IDX_WIDTH-1:0]  wr_idx_r;
  logic [1:0]            bank_full_r;
  logic                  overrun_r;

  // Combinational helpers
  logic                  in_ready_s;
  logic                  out_valid_s;
  logic                  accept_s;
  logic                  pop_s;
  logic                  frame_done_s;
  logic [IDX_WIDTH-1:0]  wr_addr_s;
  logic [1:0]            bank_full_nxt_s;
  logic [1:0]            level_s;
  logic [FRAME_LEN*DATA_WIDTH-1:0] out_data_s;

  // Handshake qualifiers; ready depends only on registered state, so a pop
  // frees the write side one cycle later rather than combinationally.
  always_comb begin
    in_ready_s   = ~bank_full_r[wr_bank_r];
    out_valid_s  = bank_full_r[rd_bank_r];
    accept_s     = in_valid & in_ready_s;
    pop_s        = out_valid_s & out_ready;
    frame_done_s = accept_s & (wr_idx_r == LAST_IDX);
  end

  // Write address: natural or bit-reversed slot order.
  always_comb begin
`ifdef FFT_BITREV_WRITE_EN
    wr_addr_s = bit_reverse(wr_idx_r);
`else
    wr_addr_s = wr_idx_r;
`endif
  end

  // Next bank_full: a fill-complete sets the write bank bit, a pop clears the
  // read bank bit. Fill needs the write bank empty and pop needs the read bank
  // full, so both can never target the same bit in one cycle.
  always_comb begin
    bank_full_nxt_s = bank_full_r;
    if (pop_s) begin
      bank_full_nxt_s[rd_bank_r] = 1'b0;
    end else begin
      bank_full_nxt_s = bank_full_nxt_s;
    end
    if (frame_done_s) begin
      bank_full_nxt_s[wr_bank_r] = 1'b1;
    end else begin
      bank_full_nxt_s = bank_full_nxt_s;
    end
  end

  // Sample storage; flush leaves contents untouched and blocks the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < FRAME_LEN; k++) begin
          bank_r[b][k] <= {DATA_WIDTH{1'b0}};
        end
      end
    end else if (flush) begin
      bank_r <= bank_r;
    end else if (accept_s) begin
      bank_r[wr_bank_r][wr_addr_s] <= in_data;
    end else begin
      bank_r <= bank_r;
    end
  end

  // Frame bookkeeping: write index, bank pointers, full flags, overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      wr_idx_r    <= ZERO_IDX;
      bank_full_r <= 2'b00;
      overrun_r   <= 1'b0;
    end else if (flush) begin
      // Flush wins over accept/pop; the sample offered now is dropped silently.
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      wr_idx_r    <= ZERO_IDX;
      bank_full_r <= 2'b00;
      overrun_r   <= 1'b0;
    end else begin
      bank_full_r <= bank_full_nxt_s;
      if (frame_done_s) begin
        wr_idx_r  <= ZERO_IDX;
        wr_bank_r <= ~wr_bank_r;
      end else if (accept_s) begin
        wr_idx_r  <= wr_idx_r + ONE_IDX;
      end else begin
        wr_idx_r  <= wr_idx_r;
      end
      if (pop_s) begin
        rd_bank_r <= ~rd_bank_r;
      end else begin
        rd_bank_r <= rd_bank_r;
      end
      if (in_valid && !in_ready_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Flatten the read bank onto the parallel output bus.
  always_comb begin
    out_data_s = {(FRAME_LEN*DATA_WIDTH){1'b0}};
    for (int k = 0; k < FRAME_LEN; k++) begin
      out_data_s[k*DATA_WIDTH +: DATA_WIDTH] = bank_r[rd_bank_r][k];
    end
  end

  // Occupancy count from the two full flags.
  always_comb begin
    level_s = {1'b0, bank_full_r[0]} + {1'b0, bank_full_r[1]};
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_data  = out_data_s;
  assign level     = level_s;
  assign full      = bank_full_r[0] & bank_full_r[1];
  assign empty     = (level_s == 2'd0) && (wr_idx_r == ZERO_IDX);
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_fft_frame_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_pingpong_buffer
//
// Directed, self-checking bench for fft_frame_pingpong_buffer with
// DATA_WIDTH=32, FRAME_LEN=16. Each task drives one scenario and checks the
// outputs against hand-computed values. Slot expectations follow the write
// ordering selected by FFT_BITREV_WRITE_EN.
// ---------------------------------------------------------------------------
module tb_fft_frame_pingpong_buffer;

  localparam int DW = 32;
  localparam int FL = 16;
  localparam int OW = DW * FL;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [1:0]    level;
  logic          full;
  logic          empty;
  logic          overrun;

  int checks;
  int errors;

  fft_frame_pingpong_buffer #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slot where sample number i of a frame is expected to land.
  function automatic int slot_of(input int i);
`ifdef FFT_BITREV_WRITE_EN
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) begin
      if (((i >> b) & 1) == 1) r = r | (1 << (3 - b));
    end
    return r;
`else
    return i;
`endif
  endfunction

  function automatic logic [DW-1:0] get_slot(input int k);
    return out_data[k*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (out_data !== {OW{1'b0}}) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
  endtask

  task automatic test_single_frame();
    reset_dut();
    for (int i = 0; i < 15; i++) push(32'(i));
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frame_early_valid got %b want 0", out_valid); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL frame_partial_empty got %b want 0", empty); end
    push(32'd15);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL frame_valid got %b want 1", out_valid); end
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL frame_level got %0d want 1", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL frame_in_ready got %b want 1", in_ready); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL frame_empty got %b want 0", empty); end
    for (int i = 0; i < FL; i++) begin
      checks++;
      if (get_slot(slot_of(i)) !== 32'(i)) begin
        errors++; $display("FAIL frame_slot%0d got %0d want %0d", slot_of(i), get_slot(slot_of(i)), i);
      end
    end
`ifdef FFT_BITREV_WRITE_EN
    checks++; if (get_slot(1) !== 32'd8) begin errors++; $display("FAIL bitrev_slot1 got %0d want 8", get_slot(1)); end
    checks++; if (get_slot(8) !== 32'd1) begin errors++; $display("FAIL bitrev_slot8 got %0d want 1", get_slot(8)); end
    checks++; if (get_slot(3) !== 32'd12) begin errors++; $display("FAIL bitrev_slot3 got %0d want 12", get_slot(3)); end
    checks++; if (get_slot(15) !== 32'd15) begin errors++; $display("FAIL bitrev_slot15 got %0d want 15", get_slot(15)); end
`else
    checks++; if (get_slot(1) !== 32'd1) begin errors++; $display("FAIL natural_slot1 got %0d want 1", get_slot(1)); end
    checks++; if (get_slot(8) !== 32'd8) begin errors++; $display("FAIL natural_slot8 got %0d want 8", get_slot(8)); end
`endif
  endtask

  task automatic test_full_overrun();
    reset_dut();
    for (int i = 0; i < 32; i++) push(32'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovr_full got %b want 1", full); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovr_in_ready got %b want 0", in_ready); end
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL ovr_level got %0d want 2", level); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre_overrun got %b want 0", overrun); end
    push(32'd999);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_overrun got %b want 1", overrun); end
    checks++; if (get_slot(0) !== 32'd0) begin errors++; $display("FAIL ovr_pop_slot0 got %0d want 0", get_slot(0)); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ovr_ready_after_pop got %b want 1", in_ready); end
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL ovr_level_after_pop got %0d want 1", level); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_after_pop got %b want 1", out_valid); end
    for (int i = 0; i < FL; i++) begin
      checks++;
      if (get_slot(slot_of(i)) !== 32'(16 + i)) begin
        errors++; $display("FAIL ovr_frame1_slot%0d got %0d want %0d", slot_of(i), get_slot(slot_of(i)), 16 + i);
      end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_streaming();
    int   sent;
    int   frames;
    logic acc;
    logic pp;
    reset_dut();
    sent = 0; frames = 0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && frames < 4; cyc++) begin
      in_valid = (sent < 64);
      in_data  = 32'(sent);
      acc = in_valid & in_ready;
      pp  = out_valid & out_ready;
      if (pp) begin
        checks++;
        if (get_slot(0) !== 32'(frames * 16)) begin
          errors++; $display("FAIL stream_f%0d_slot0 got %0d want %0d", frames, get_slot(0), frames * 16);
        end
        checks++;
        if (get_slot(15) !== 32'(frames * 16 + 15)) begin
          errors++; $display("FAIL stream_f%0d_slot15 got %0d want %0d", frames, get_slot(15), frames * 16 + 15);
        end
        frames++;
      end
      checks++;
      if (level > 2'd1) begin errors++; $display("FAIL stream_level got %0d want <=1", level); end
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (frames !== 4) begin errors++; $display("FAIL stream_frames got %0d want 4", frames); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL stream_overrun got %b want 0", overrun); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int i = 0; i < 31; i++) push(32'(i));
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL b2b_pre_level got %0d want 1", level); end
    in_valid = 1'b1; in_data = 32'd31; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL b2b_level got %0d want 1", level); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid got %b want 1", out_valid); end
    checks++; if (get_slot(15) !== 32'd31) begin errors++; $display("FAIL b2b_slot15 got %0d want 31", get_slot(15)); end
    checks++; if (get_slot(0) !== 32'd16) begin errors++; $display("FAIL b2b_slot0 got %0d want 16", get_slot(0)); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL b2b_full got %b want 0", full); end
  endtask

  task automatic test_flush();
    reset_dut();
    for (int i = 0; i < 32; i++) push(32'(i));
    push(32'd500);
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL flush_clears_overrun got %b want 0", overrun); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL flush_full_level got %0d want 0", level); end
    for (int i = 0; i < 7; i++) push(32'(50 + i));
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL flush_partial_empty got %b want 0", empty); end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'd77;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b want 1", empty); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL flush_level got %0d want 0", level); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL flush_overrun got %b want 0", overrun); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    for (int i = 0; i < 16; i++) push(32'(100 + i));
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_new_valid got %b want 1", out_valid); end
    checks++; if (get_slot(0) !== 32'd100) begin errors++; $display("FAIL flush_new_slot0 got %0d want 100", get_slot(0)); end
    checks++; if (get_slot(15) !== 32'd115) begin errors++; $display("FAIL flush_new_slot15 got %0d want 115", get_slot(15)); end
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL flush_new_level got %0d want 1", level); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    for (int i = 0; i < 32; i++) push(32'(200 + i));
    push(32'd300);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL arst_pre_overrun got %b want 1", overrun); end
    // Assert reset mid-cycle, well away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL arst_level got %0d want 0", level); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL arst_full got %b want 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty got %b want 1", empty); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL arst_overrun got %b want 0", overrun); end
    checks++; if (out_data !== {OW{1'b0}}) begin errors++; $display("FAIL arst_out_data got %h want 0", out_data); end
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_frame();
    test_full_overrun();
    test_streaming();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
